// File: rtl/fetch_pcgen_pkg.sv
// Shared types and constants for the fetch PC generator: FSM states, the
// F/D payload, the instruction-bus request/response structs and PC helpers.
package fetch_pcgen_pkg;

    localparam logic [63:0] PCINIT = 64'h8000_0000;
    localparam logic [63:0] PC_STEP = 64'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
        logic        misalign;
    } fetch_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    // Sequential PC; wraps modulo 2^64 with no special case.
    function automatic logic [63:0] pc_next(input logic [63:0] pc);
        return pc + PC_STEP;
    endfunction

    function automatic logic pc_misaligned(input logic [63:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pcgen_if.sv
// Instruction-bus bundle between the fetch stage (master) and memory (slave).
// Handshake: ireq.valid/addr stay stable from assertion until data_ok returns.
interface fetch_pcgen_if;
    import fetch_pcgen_pkg::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;

    modport master (
        output ireq,
        input  iresp
    );

    modport slave (
        input  ireq,
        output iresp
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// Single-entry holding register for a fetched instruction that arrived while
// the downstream F/D register was stalled.
module fetch_hold_buf
    import fetch_pcgen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        clear_i,
    input  fetch_data_t load_data_i,
    output logic        valid_o,
    output fetch_data_t data_o
);

    logic        valid_q;
    logic        valid_d;
    fetch_data_t data_q;
    fetch_data_t data_d;

    // Clear wins over load so a redirect can never leave a stale entry behind.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fetch_pcgen.sv
// Fetch-stage PC generator: owns the fetch PC, issues one ibus request at a
// time, applies decode redirects and hands fetched words to the F/D register.
module fetch_pcgen #(
    parameter logic [63:0] PCINIT = fetch_pcgen_pkg::PCINIT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          PCSel,
    input  logic [63:0]                   pc_address,
    input  logic                          stallF,
    fetch_pcgen_if.master                 ibus,
    output logic                          f_valid,
    output logic [63:0]                   f_pc,
    output logic [31:0]                   f_raw_instr,
    output logic                          f_misalign,
    output fetch_pcgen_pkg::fetch_state_t dbg_state
);
    import fetch_pcgen_pkg::*;

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [63:0]  pc_q;
    logic [63:0]  pc_d;
    logic [63:0]  target_q;
    logic [63:0]  target_d;

    logic         req_valid;
    logic         data_ok;
    logic         misaligned;
    fetch_data_t  f_d;
    fetch_data_t  fetched;

    logic         hold_load;
    logic         hold_clear;
    logic         hold_valid;
    fetch_data_t  hold_data;

    // addr_ok is not needed: the request stays up until data_ok anyway.
    logic         unused_addr_ok;
    assign unused_addr_ok = ibus.iresp.addr_ok;

    assign data_ok    = ibus.iresp.data_ok;
    assign misaligned = pc_misaligned(pc_q);

    always_comb begin
        fetched = '{valid: 1'b1, pc: pc_q, raw_instr: ibus.iresp.data, misalign: 1'b0};
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        req_valid  = 1'b0;
        f_d        = '0;
        hold_load  = 1'b0;
        hold_clear = 1'b0;

        case (state_q)
            FETCH: begin
                if (misaligned) begin
                    // Fault entry replaces the request; nothing is outstanding.
                    f_d = '{valid: 1'b1, pc: pc_q, raw_instr: 32'd0, misalign: 1'b1};
                    if (PCSel) begin
                        pc_d = pc_address;
                    end else if (!stallF) begin
                        state_d = FAULT;
                    end
                end else begin
                    req_valid = 1'b1;
                    if (data_ok) begin
                        if (PCSel) begin
                            pc_d = pc_address;
                        end else begin
                            f_d = fetched;
                            if (stallF) begin
                                hold_load = 1'b1;
                                state_d   = HOLD;
                            end else begin
                                pc_d = pc_next(pc_q);
                            end
                        end
                    end else if (PCSel) begin
                        target_d = pc_address;
                        state_d  = DRAIN;
                    end
                end
            end

            HOLD: begin
                f_d       = hold_data;
                f_d.valid = hold_valid;
                if (PCSel) begin
                    hold_clear = 1'b1;
                    pc_d       = pc_address;
                    state_d    = FETCH;
                end else if (!stallF) begin
                    hold_clear = 1'b1;
                    pc_d       = pc_next(pc_q);
                    state_d    = FETCH;
                end
            end

            DRAIN: begin
                // Old request must complete; its data is thrown away.
                req_valid = 1'b1;
                if (data_ok) begin
                    pc_d    = PCSel ? pc_address : target_q;
                    state_d = FETCH;
                end else if (PCSel) begin
                    target_d = pc_address;
                end
            end

            FAULT: begin
                if (PCSel) begin
                    pc_d    = pc_address;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase

        if (reset) begin
            req_valid = 1'b0;
            f_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= PCINIT;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
        end
    end

    fetch_hold_buf u_hold_buf (
        .clk         (clk),
        .reset       (reset),
        .load_i      (hold_load),
        .clear_i     (hold_clear),
        .load_data_i (fetched),
        .valid_o     (hold_valid),
        .data_o      (hold_data)
    );

    assign ibus.ireq   = '{valid: req_valid, addr: pc_q};
    assign f_valid     = f_d.valid;
    assign f_pc        = f_d.pc;
    assign f_raw_instr = f_d.raw_instr;
    assign f_misalign  = f_d.misalign;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_pcgen.sv
// Directed bench for fetch_pcgen: stimulus pushes expected bus completions and
// F/D deliveries into queues; a negedge monitor pops and compares them.
module tb_fetch_pcgen;
    import fetch_pcgen_pkg::*;

    localparam logic [63:0] PC0 = 64'h8000_0000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         PCSel = 1'b0;
    logic [63:0]  pc_address = '0;
    logic         stallF = 1'b0;
    logic         f_valid;
    logic [63:0]  f_pc;
    logic [31:0]  f_raw_instr;
    logic         f_misalign;
    fetch_state_t dbg_state;

    fetch_pcgen_if ibus ();

    fetch_pcgen #(.PCINIT(PC0)) dut (
        .clk         (clk),
        .reset       (reset),
        .PCSel       (PCSel),
        .pc_address  (pc_address),
        .stallF      (stallF),
        .ibus        (ibus),
        .f_valid     (f_valid),
        .f_pc        (f_pc),
        .f_raw_instr (f_raw_instr),
        .f_misalign  (f_misalign),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    // Scoreboard
    logic [63:0] exp_req_q[$];
    logic [96:0] exp_f_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Per-cycle expectations set by the stimulus, checked by the monitor
    logic         chk_reset_out = 1'b0;
    logic         chk_idle = 1'b0;
    logic         chk_addr_en = 1'b0;
    logic [63:0]  chk_addr = '0;
    logic         chk_state_en = 1'b0;
    fetch_state_t chk_state = FETCH;
    logic         chk_drain = 1'b0;

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] e_req;
        logic [96:0] e_f;
        if (chk_reset_out) begin
            cmp("rst_ireq_valid", 128'(ibus.ireq.valid), 128'd0);
            cmp("rst_f_valid", 128'(f_valid), 128'd0);
            cmp("rst_f_pc", 128'(f_pc), 128'd0);
            cmp("rst_f_raw", 128'(f_raw_instr), 128'd0);
            cmp("rst_f_misalign", 128'(f_misalign), 128'd0);
        end
        if (chk_idle)
            cmp("no_ireq", 128'(ibus.ireq.valid), 128'd0);
        if (chk_addr_en)
            cmp("ireq_addr", 128'({ibus.ireq.valid, ibus.ireq.addr}), 128'({1'b1, chk_addr}));
        if (chk_state_en)
            cmp("state", 128'(dbg_state), 128'(chk_state));
        if (chk_drain) begin
            cmp("req_q_left", 128'(exp_req_q.size()), 128'd0);
            cmp("f_q_left", 128'(exp_f_q.size()), 128'd0);
        end
        if (!reset) begin
            if (ibus.ireq.valid && ibus.iresp.data_ok) begin
                if (exp_req_q.size() == 0) begin
                    cmp("req_unexpected", 128'(ibus.ireq.addr), 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
                end else begin
                    e_req = exp_req_q.pop_front();
                    cmp("req_done_addr", 128'(ibus.ireq.addr), 128'(e_req));
                end
            end
            if (f_valid) begin
                if (exp_f_q.size() == 0) begin
                    cmp("f_unexpected", 128'({f_pc, f_raw_instr, f_misalign}), 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
                end else begin
                    e_f = exp_f_q.pop_front();
                    cmp("f_entry", 128'({f_pc, f_raw_instr, f_misalign}), 128'(e_f));
                end
            end
        end
    end

    // Driver tasks
    task automatic drive(input logic sel, input logic [63:0] tgt, input logic stall,
                         input logic dok, input logic [31:0] data);
        PCSel               = sel;
        pc_address          = tgt;
        stallF              = stall;
        ibus.iresp.addr_ok  = dok;
        ibus.iresp.data_ok  = dok;
        ibus.iresp.data     = data;
        chk_reset_out       = 1'b0;
        chk_idle            = 1'b0;
        chk_addr_en         = 1'b0;
        chk_state_en        = 1'b0;
        chk_drain           = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input fetch_state_t s);
        chk_state_en = 1'b1;
        chk_state    = s;
    endtask

    task automatic expect_addr(input logic [63:0] a);
        chk_addr_en = 1'b1;
        chk_addr    = a;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        chk_reset_out = 1'b1;
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        chk_reset_out = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // One request at addr: a wait cycle, then data_ok with data, no stall.
    task automatic fetch_ok(input logic [63:0] addr, input logic [31:0] data);
        exp_req_q.push_back(addr);
        exp_f_q.push_back({addr, data, 1'b0});
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        expect_addr(addr);
        expect_state(FETCH);
        tick();
        drive(1'b0, '0, 1'b0, 1'b1, data);
        tick();
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        do_reset();

        // Sequential fetch
        fetch_ok(PC0,              32'h0000_0013);
        fetch_ok(PC0 + 64'h4,      32'h0010_0093);
        fetch_ok(PC0 + 64'h8,      32'h0020_0113);

        // Stall on delivery: entry held 4 cycles, no request meanwhile
        do_reset();
        fetch_ok(PC0, 32'h0000_0013);
        exp_req_q.push_back(PC0 + 64'h4);
        for (int i = 0; i < 4; i++) exp_f_q.push_back({PC0 + 64'h4, 32'h00a0_0093, 1'b0});
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        expect_addr(PC0 + 64'h4);
        tick();
        drive(1'b0, '0, 1'b1, 1'b1, 32'h00a0_0093);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        chk_idle = 1'b1;
        expect_state(HOLD);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        chk_idle = 1'b1;
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        chk_idle = 1'b1;
        tick();

        // Redirect two cycles before data_ok: data discarded
        exp_req_q.push_back(PC0 + 64'h8);
        drive(1'b1, PC0 + 64'h100, 1'b0, 1'b0, '0);
        expect_addr(PC0 + 64'h8);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        expect_addr(PC0 + 64'h8);
        expect_state(DRAIN);
        tick();
        drive(1'b0, '0, 1'b0, 1'b1, 32'hdead_beef);
        tick();
        fetch_ok(PC0 + 64'h100, 32'h0010_8093);

        // Two redirects during DRAIN: latest wins
        exp_req_q.push_back(PC0 + 64'h104);
        drive(1'b1, PC0 + 64'h200, 1'b0, 1'b0, '0);
        expect_addr(PC0 + 64'h104);
        tick();
        drive(1'b1, PC0 + 64'h300, 1'b0, 1'b0, '0);
        expect_state(DRAIN);
        tick();
        drive(1'b0, '0, 1'b0, 1'b1, 32'hbad0_0001);
        expect_addr(PC0 + 64'h104);
        tick();
        fetch_ok(PC0 + 64'h300, 32'h0030_0193);

        // Redirect with data_ok in the same cycle to a misaligned target
        exp_req_q.push_back(PC0 + 64'h304);
        drive(1'b1, PC0 + 64'h102, 1'b0, 1'b1, 32'hbad0_0002);
        tick();
        for (int i = 0; i < 2; i++) exp_f_q.push_back({PC0 + 64'h102, 32'h0, 1'b1});
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        chk_idle = 1'b1;
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        chk_idle = 1'b1;
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        chk_idle = 1'b1;
        expect_state(FAULT);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        chk_idle = 1'b1;
        tick();
        drive(1'b1, PC0, 1'b0, 1'b0, '0);
        chk_idle = 1'b1;
        tick();
        fetch_ok(PC0, 32'h0040_0213);

        // PC wrap at the top of the address space
        exp_req_q.push_back(PC0 + 64'h4);
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, 32'hbad0_0003);
        tick();
        fetch_ok(64'hFFFF_FFFF_FFFF_FFFC, 32'h0050_0293);
        fetch_ok(64'h0, 32'h0060_0313);

        // Reset while draining: restart at PCINIT
        drive(1'b1, PC0 + 64'h400, 1'b0, 1'b0, '0);
        expect_addr(64'h4);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        expect_state(DRAIN);
        tick();
        do_reset();
        fetch_ok(PC0, 32'h0070_0393);

        drive(1'b0, '0, 1'b0, 1'b0, '0);
        chk_drain = 1'b1;
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule

// File: doc/fetch_pcgen.md
Name: fetch_pcgen

Overview:
- Fetch-stage PC generator and instruction-bus requester. It is the receiving end of the decode-stage redirect (PCSel / pc_address).
- Holds the architectural fetch PC, issues ibus requests, and delivers fetched instructions to the F/D pipeline register.
- Applies decode redirects. When a redirect arrives while a bus transaction is still in flight, the returning data is discarded and the transaction is never aborted.

Parameters:
- PCINIT, 64'h8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- PCSel  in  1  redirect request from decode. Upstream qualifies it, so it is asserted only for an advancing decode instruction.
- pc_address  in  64  redirect target. Bit 0 is already cleared by the sender.
- stallF  in  1  downstream cannot accept a fetched instruction this cycle.
- ireq  out  ibus_req_t  {valid, addr}. ibus protocol: valid/addr held stable until addr_ok/data_ok.
- iresp  in  ibus_resp_t  {addr_ok, data_ok, data[31:0]}.
- f_valid  out  1  fetched instruction valid toward the F/D register.
- f_pc  out  64  PC of the delivered instruction.
- f_raw_instr  out  32  instruction word.
- f_misalign  out  1  delivered entry is an instruction-address-misaligned fault. f_raw_instr is 0 in that case.

Behaviour:
- Reset (synchronous, active-high):
  - pc = PCINIT; state = FETCH; redirect_pending = 0.
  - Outputs: ireq.valid = 0 in the reset cycle; f_valid = 0, f_pc = 0, f_raw_instr = 0, f_misalign = 0.
  - Reset mid-transaction: state is dropped immediately. The ibus side tolerates an abandoned request after reset.
- State FETCH:
  - ireq.valid = 1 and ireq.addr = pc, held until data_ok.
  - If pc[1:0] != 0: no request is issued. The block presents f_valid = 1 with f_misalign = 1 and f_pc = pc, held while stallF, then moves to FAULT.
  - On data_ok with no PCSel:
    - If ~stallF: f_valid = 1 for exactly that cycle with f_pc = pc and f_raw_instr = data; pc <= pc + 4; remain in FETCH. The next request starts the following cycle.
    - If stallF: capture data into a holding register and go to HOLD.
  - On data_ok with PCSel in the same cycle: discard data (f_valid = 0), pc <= pc_address, stay in FETCH.
  - PCSel with no data_ok while a request is outstanding: save target <= pc_address and go to DRAIN. ireq keeps the old address.
  - PCSel with no request outstanding: pc <= pc_address directly.
- State HOLD:
  - f_valid = 1 with the held pc and instruction; ireq.valid = 0.
  - When ~stallF: pc <= pc + 4, go to FETCH.
  - PCSel has priority: drop the held entry, pc <= pc_address, go to FETCH, f_valid = 0 next cycle.
- State DRAIN:
  - ireq stays valid at the old address; f_valid = 0.
  - A further PCSel overwrites target (latest wins).
  - On data_ok: discard data, pc <= target (or pc_address if PCSel is also asserted in this cycle), go to FETCH.
- State FAULT:
  - ireq.valid = 0; f_valid = 0 after the fault entry has been accepted.
  - Leaves only on PCSel: pc <= pc_address, go to FETCH.
- Arithmetic: pc + 4 wraps mod 2^64 with no special case. 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
- Invariants:
  - Never more than one outstanding ibus transaction.
  - f_valid never asserts for data belonging to a pre-redirect transaction.
  - Latency from redirect to the first request at the target: 1 cycle if nothing is outstanding; data_ok + 1 cycle otherwise.

Decomposition:
- Shared package (pipes):
  - fetch_state_t enum {FETCH, HOLD, DRAIN, FAULT}.
  - fetch_data_t {valid, pc, raw_instr, misalign}, consumed by the F/D register.
  - PCINIT constant.
- ibus_req_t / ibus_resp_t stay in common.
- One sub-module, fetch_hold_buf: the single-entry holding register with load/clear/valid. Everything else lives in fetch_pcgen.

Test Plan:
- Reset, then data_ok in 1 cycle with data 32'h00000013 per request, stallF = 0 → ireq.addr 8000_0000, 8000_0004, 8000_0008; f_valid pulses with matching f_pc.
- stallF = 1 for 3 cycles when data_ok arrives at 8000_0004 → f_valid held 4 cycles with pc 8000_0004; no ireq.valid during HOLD; next request at 8000_0008.
- PCSel = 1, pc_address = 8000_0100 asserted 2 cycles before data_ok at 8000_0008 → data discarded, f_valid = 0, next ireq.addr = 8000_0100.
- Two PCSel pulses (8000_0200, then 8000_0300) during DRAIN → only 8000_0300 is fetched.
- PCSel to 8000_0102 → f_misalign = 1 with f_pc = 8000_0102; no ireq; FAULT until PCSel to 8000_0000 resumes fetch.
- reset asserted during DRAIN → next cycle pc = 8000_0000, outputs cleared, fetch restarts at PCINIT.
